// File: rtl/fetch_queue.sv
// Instruction-fetch front end: owns the fetch PC, issues credit-limited requests to a
// synchronous instruction port and buffers returned words with their addresses for decode.
module fetch_queue #(
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter int unsigned           DATA_WIDTH = 32,
  parameter int unsigned           DEPTH      = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
  parameter int unsigned           PC_STEP    = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    flush_i,
  input  logic [ADDR_WIDTH-1:0]   new_pc_i,
  input  logic                    halt_i,
  output logic [ADDR_WIDTH-1:0]   pc_o,
  output logic                    ce_o,
  input  logic [DATA_WIDTH-1:0]   inst_i,
  input  logic                    inst_ready_i,
  output logic                    inst_valid_o,
  output logic [DATA_WIDTH-1:0]   inst_o,
  output logic [ADDR_WIDTH-1:0]   inst_addr_o,
  output logic [$clog2(DEPTH):0]  count_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [ADDR_WIDTH-1:0] pc_q;
  logic [ADDR_WIDTH-1:0] inflight_addr_q;
  logic                  inflight_q;
  logic [PW-1:0]         rd_ptr;
  logic [PW-1:0]         wr_ptr;
  logic [CW-1:0]         count_q;
  logic [CW-1:0]         credit_used;
  logic                  issue;
  logic                  push;
  logic                  pop;

  logic [DATA_WIDTH-1:0] mem_data [DEPTH];
  logic [ADDR_WIDTH-1:0] mem_addr [DEPTH];

  // Credit includes the word in flight so a returning response always has a free slot.
  always_comb begin
    credit_used = count_q + CW'(inflight_q);
    issue       = !rst_i && !flush_i && !halt_i && (credit_used < CW'(DEPTH));
    push        = !rst_i && !flush_i && inflight_q;
    pop         = !rst_i && !flush_i && (count_q != '0) && inst_ready_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc_q            <= RESET_PC;
      inflight_q      <= 1'b0;
      inflight_addr_q <= '0;
      rd_ptr          <= '0;
      wr_ptr          <= '0;
      count_q         <= '0;
    end else if (flush_i) begin
      pc_q       <= new_pc_i;
      inflight_q <= 1'b0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count_q    <= '0;
    end else begin
      if (issue) begin
        pc_q            <= pc_q + ADDR_WIDTH'(PC_STEP);
        inflight_addr_q <= pc_q;
        inflight_q      <= 1'b1;
      end else begin
        inflight_q <= 1'b0;
      end
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_data[wr_ptr] <= inst_i;
      mem_addr[wr_ptr] <= inflight_addr_q;
    end
  end

  assign pc_o         = pc_q;
  assign ce_o         = issue;
  assign count_o      = count_q;
  assign inst_valid_o = (count_q != '0);
  assign inst_o       = inst_valid_o ? mem_data[rd_ptr] : '0;
  assign inst_addr_o  = inst_valid_o ? mem_addr[rd_ptr] : '0;

endmodule

// File: tb/tb_fetch_queue.sv
// Randomized bench for fetch_queue: phased random control inputs, a memory model that
// answers one cycle after ce_o, and a queue-based reference model of the fetch front end.
module tb_fetch_queue;

  localparam int DEPTH = 4;
  localparam logic [31:0] MASK = 32'hA5A5_0000;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        flush_i = 1'b0;
  logic [31:0] new_pc_i = '0;
  logic        halt_i = 1'b0;
  logic [31:0] pc_o;
  logic        ce_o;
  logic [31:0] inst_i = '0;
  logic        inst_ready_i = 1'b0;
  logic        inst_valid_o;
  logic [31:0] inst_o;
  logic [31:0] inst_addr_o;
  logic [2:0]  count_o;

  fetch_queue #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(DEPTH), .RESET_PC(32'h0), .PC_STEP(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i), .new_pc_i(new_pc_i), .halt_i(halt_i),
    .pc_o(pc_o), .ce_o(ce_o), .inst_i(inst_i), .inst_ready_i(inst_ready_i),
    .inst_valid_o(inst_valid_o), .inst_o(inst_o), .inst_addr_o(inst_addr_o), .count_o(count_o)
  );

  always #5 clk_i = ~clk_i;

  // Synchronous instruction memory: word = address ^ MASK, one cycle after the request.
  always @(posedge clk_i) if (ce_o) inst_i <= pc_o ^ MASK;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cycle=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  // Reference model
  logic [31:0] m_pc;
  bit          m_inflight;
  logic [31:0] m_inflight_addr;
  logic [31:0] m_q[$];

  function automatic bit chance(int pct);
    return $urandom_range(99) < pct;
  endfunction

  function automatic logic [31:0] pick_pc();
    case ($urandom_range(2))
      0:       return 32'h0000_0200;
      1:       return 32'hFFFF_FFF8;
      default: return $urandom & 32'hFFFF_FFFC;
    endcase
  endfunction

  task automatic model_step(input bit exp_ce);
    if (rst_i) begin
      m_pc = 32'h0; m_inflight = 0; m_q.delete();
    end else if (flush_i) begin
      m_pc = new_pc_i; m_inflight = 0; m_q.delete();
    end else begin
      if (m_q.size() != 0 && inst_ready_i) void'(m_q.pop_front());
      if (m_inflight) m_q.push_back(m_inflight_addr);
      if (exp_ce) begin
        m_inflight_addr = m_pc;
        m_inflight = 1;
        m_pc = m_pc + 32'd4;
      end else begin
        m_inflight = 0;
      end
    end
  endtask

  // Phase table: cycles, %ready, %halt, %flush, %reset
  localparam int NPH = 12;
  int ph_cyc [NPH] = '{40, 30, 20,   1, 30, 15,   6, 10, 3,  10, 300, 300};
  int ph_rdy [NPH] = '{100, 0, 100, 100, 100, 0, 100, 100, 0, 100, 60, 85};
  int ph_hlt [NPH] = '{0,  0,  0,   0,  0,  0, 100,  0,  0,   0, 20, 10};
  int ph_fls [NPH] = '{0,  0,  0, 100,  0,  0,   0,  0,  0,   0,  5,  3};
  int ph_rst [NPH] = '{0,  0,  0,   0,  0,  0,   0,  0, 100,  0,  2,  1};

  initial begin
    bit exp_ce;
    logic [31:0] exp_addr;
    rst_i = 1'b1;
    @(posedge clk_i);
    @(posedge clk_i);
    m_pc = 32'h0; m_inflight = 0; m_inflight_addr = '0; m_q.delete();
    for (int p = 0; p < NPH; p++) begin
      for (int c = 0; c < ph_cyc[p]; c++) begin
        @(negedge clk_i);
        cyc++;
        rst_i        = chance(ph_rst[p]);
        flush_i      = chance(ph_fls[p]);
        halt_i       = chance(ph_hlt[p]);
        inst_ready_i = chance(ph_rdy[p]);
        new_pc_i     = pick_pc();
        #1;
        exp_ce   = !rst_i && !flush_i && !halt_i && ((m_q.size() + int'(m_inflight)) < DEPTH);
        exp_addr = (m_q.size() != 0) ? m_q[0] : 32'h0;
        check("pc_o",         64'(pc_o),         64'(m_pc));
        check("ce_o",         64'(ce_o),         64'(exp_ce));
        check("count_o",      64'(count_o),      64'(m_q.size()));
        check("inst_valid_o", 64'(inst_valid_o), 64'(m_q.size() != 0));
        check("inst_addr_o",  64'(inst_addr_o),  64'(exp_addr));
        check("inst_o",       64'(inst_o),       64'((m_q.size() != 0) ? (exp_addr ^ MASK) : 32'h0));
        @(posedge clk_i);
        model_step(exp_ce);
      end
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
